// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the ID-stage hazard scoreboard: stage indices,
// scoreboard entry layout and forward-select width helper.
package pipe_pkg;
    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;

    // Entry fields are sized for the largest supported configuration; narrower
    // register indices and stage numbers are zero-extended on the way in.
    localparam int SB_DST_W = 8;
    localparam int SB_RDY_W = 4;

    typedef struct packed {
        logic                v;
        logic [SB_DST_W-1:0] dst;
        logic [SB_RDY_W-1:0] rdy;
    } sb_entry_t;

    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// ID-stage hazard bus: decoded operand/destination info in, stall/bubble/forward controls out.
interface id_hazard_scoreboard_if
    import pipe_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
) ();
    localparam int SEL_W = sel_w(DEPTH);

    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_rs_used;
    logic             id_rt_used;
    logic             id_in_id;
    logic             id_regwrite;
    logic [REG_W-1:0] id_dst;
    logic             id_is_load;
    logic             id_flush;
    logic             pipe_hold;
    logic             cnt_clr;
    logic             pc_ifid_we;
    logic             bubble;
    logic [SEL_W-1:0] fwd_rs_sel;
    logic [SEL_W-1:0] fwd_rt_sel;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_in_id,
               id_regwrite, id_dst, id_is_load, id_flush, pipe_hold, cnt_clr,
        input  pc_ifid_we, bubble, fwd_rs_sel, fwd_rt_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_in_id,
               id_regwrite, id_dst, id_is_load, id_flush, pipe_hold, cnt_clr,
        output pc_ifid_we, bubble, fwd_rs_sel, fwd_rt_sel, stall_cnt
    );
endinterface

// File: rtl/sb_match.sv
// Priority finder: youngest valid scoreboard entry writing the source register,
// plus whether that producer is still too far from its ready stage.
module sb_match
    import pipe_pkg::*;
#(
    parameter int REG_W     = 5,
    parameter int DEPTH     = 3,
    parameter int RF_BYPASS = 0,
    parameter int KW        = 2
) (
    input  sb_entry_t [DEPTH-1:0] i_ents,
    input  logic [REG_W-1:0]      i_src,
    input  logic                  i_used,
    input  logic                  i_in_id,
    output logic                  o_hit,
    output logic [KW-1:0]         o_k,
    output logic                  o_late
);
    // A write-through regfile already returns the WB value, so that stage is never a hazard.
    localparam int NSCAN = (RF_BYPASS != 0) ? DEPTH - 1 : DEPTH;

    always_comb begin
        o_hit  = 1'b0;
        o_k    = '0;
        o_late = 1'b0;
        // Scan oldest to youngest so the youngest match is the last one written.
        for (int k = NSCAN - 1; k >= 0; k--) begin
            if (i_ents[k].v && i_used && (i_src != '0) &&
                (i_ents[k].dst == SB_DST_W'(i_src))) begin
                o_hit  = 1'b1;
                o_k    = KW'(k);
                o_late = ((i_in_id ? k : k + 1) < int'(i_ents[k].rdy));
            end
        end
    end
endmodule

// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard unit: shift-register scoreboard of in-flight writes below ID,
// stall/bubble generation, ID forward selects and a saturating stall counter.
module id_hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int REG_W     = 5,
    parameter int DEPTH     = 3,
    parameter int ALU_RDY   = STG_MEM,
    parameter int LOAD_RDY  = STG_WB,
    parameter int RF_BYPASS = 0,
    parameter int CNT_W     = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    id_hazard_scoreboard_if.slave bus
);
    localparam int SEL_W = sel_w(DEPTH);

    sb_entry_t [DEPTH-1:0]   r_sb;
    logic [CNT_W-1:0]        r_cnt;

    logic [1:0][REG_W-1:0]   w_src;
    logic [1:0]              w_used;
    logic [1:0]              w_hit;
    logic [1:0]              w_late;
    logic [1:0][SEL_W-1:0]   w_k;
    logic [1:0][SEL_W-1:0]   w_sel;
    logic                    w_haz;
    logic                    w_bubble;
    sb_entry_t               w_new;

    assign w_src  = {bus.id_rt, bus.id_rs};
    assign w_used = {bus.id_rt_used, bus.id_rs_used};

    for (genvar i = 0; i < 2; i++) begin : g_op
        sb_match #(
            .REG_W     (REG_W),
            .DEPTH     (DEPTH),
            .RF_BYPASS (RF_BYPASS),
            .KW        (SEL_W)
        ) u_match (
            .i_ents  (r_sb),
            .i_src   (w_src[i]),
            .i_used  (w_used[i]),
            .i_in_id (bus.id_in_id),
            .o_hit   (w_hit[i]),
            .o_k     (w_k[i]),
            .o_late  (w_late[i])
        );
        assign w_sel[i] = (w_hit[i] && !w_late[i]) ? w_k[i] + SEL_W'(1) : '0;
    end

    // A flushed instruction never stalls; it is simply replaced by a bubble.
    assign w_haz    = bus.id_valid & ~bus.id_flush & (|w_late);
    assign w_bubble = w_haz | bus.id_flush;

    assign bus.pc_ifid_we = ~bus.pipe_hold & ~w_haz;
    assign bus.bubble     = ~bus.pipe_hold & w_bubble;
    assign bus.fwd_rs_sel = w_sel[0];
    assign bus.fwd_rt_sel = w_sel[1];
    assign bus.stall_cnt  = r_cnt;

    assign w_new.v   = bus.id_valid & bus.id_regwrite & (bus.id_dst != '0) & ~w_bubble;
    assign w_new.dst = SB_DST_W'(bus.id_dst);
    assign w_new.rdy = bus.id_is_load ? SB_RDY_W'(LOAD_RDY) : SB_RDY_W'(ALU_RDY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb <= '0;
        end else if (!bus.pipe_hold) begin
            for (int k = DEPTH - 1; k > 0; k--) r_sb[k] <= r_sb[k-1];
            r_sb[0] <= w_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!bus.pipe_hold) begin
            if (bus.cnt_clr)                r_cnt <= '0;
            else if (w_haz && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed and random checks of the ID hazard scoreboard against a queue-of-stages
// model: each stage holds the instruction that entered EX that many cycles ago.
module tb_id_hazard_scoreboard;
    import pipe_pkg::*;

    localparam int REG_W    = 5;
    localparam int DEPTH    = 3;
    localparam int CNT_W    = 16;
    localparam int ALU_RDY  = 1;
    localparam int LOAD_RDY = 2;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_hazard_scoreboard_if #(.REG_W(REG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    id_hazard_scoreboard #(
        .REG_W(REG_W), .DEPTH(DEPTH), .ALU_RDY(ALU_RDY), .LOAD_RDY(LOAD_RDY),
        .RF_BYPASS(0), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // In-flight instructions, index = stages below ID (0 = EX).
    int m_v   [DEPTH];
    int m_dst [DEPTH];
    int m_ld  [DEPTH];
    int m_cnt = 0;
    int e_haz, e_bub;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) begin
            m_v[k] = 0; m_dst[k] = 0; m_ld[k] = 0;
        end
        m_cnt = 0;
    endtask

    // The youngest writer of src produces its value at stage rdy; the consumer
    // needs it when that writer sits at stage k (ID use) or k+1 (EX use).
    task automatic model_src(input int src, input int used, input int in_id,
                             output int late, output int sel);
        late = 0;
        sel  = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (m_v[k] != 0 && m_dst[k] == src && src != 0 && used != 0) begin
                int ready_at, needed_at;
                ready_at  = (m_ld[k] != 0) ? LOAD_RDY : ALU_RDY;
                needed_at = (in_id != 0) ? k : k + 1;
                late = (needed_at < ready_at) ? 1 : 0;
                sel  = late ? 0 : k + 1;
                break;
            end
        end
    endtask

    task automatic check_all(input string tag);
        int l1, s1, l2, s2;
        model_src(int'(bus.id_rs), int'(bus.id_rs_used), int'(bus.id_in_id), l1, s1);
        model_src(int'(bus.id_rt), int'(bus.id_rt_used), int'(bus.id_in_id), l2, s2);
        e_haz = (bus.id_valid && !bus.id_flush && (l1 != 0 || l2 != 0)) ? 1 : 0;
        e_bub = (e_haz != 0 || bus.id_flush) ? 1 : 0;
        chk({tag, "_we"},  int'(bus.pc_ifid_we), bus.pipe_hold ? 0 : (e_haz != 0 ? 0 : 1));
        chk({tag, "_bub"}, int'(bus.bubble),     bus.pipe_hold ? 0 : e_bub);
        chk({tag, "_rs"},  int'(bus.fwd_rs_sel), s1);
        chk({tag, "_rt"},  int'(bus.fwd_rt_sel), s2);
        chk({tag, "_cnt"}, int'(bus.stall_cnt),  m_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!bus.pipe_hold) begin
            if (bus.cnt_clr)                         m_cnt = 0;
            else if (e_haz != 0 && m_cnt < CNT_MAX)  m_cnt++;
            for (int k = DEPTH - 1; k > 0; k--) begin
                m_v[k] = m_v[k-1]; m_dst[k] = m_dst[k-1]; m_ld[k] = m_ld[k-1];
            end
            m_v[0]   = (bus.id_valid && bus.id_regwrite && bus.id_dst != 0 && e_bub == 0) ? 1 : 0;
            m_dst[0] = int'(bus.id_dst);
            m_ld[0]  = int'(bus.id_is_load);
        end
        #1;
    endtask

    task automatic drv(input logic v, input int rs, input int rt, input logic rsu,
                       input logic rtu, input logic inid, input logic rw, input int dst,
                       input logic ld, input logic fl, input logic hold, input logic clr);
        bus.id_valid    = v;
        bus.id_rs       = rs[REG_W-1:0];
        bus.id_rt       = rt[REG_W-1:0];
        bus.id_rs_used  = rsu;
        bus.id_rt_used  = rtu;
        bus.id_in_id    = inid;
        bus.id_regwrite = rw;
        bus.id_dst      = dst[REG_W-1:0];
        bus.id_is_load  = ld;
        bus.id_flush    = fl;
        bus.pipe_hold   = hold;
        bus.cnt_clr     = clr;
        #1;
    endtask

    task automatic i_alu(input int d, input int rs, input int rt);
        drv(1, rs, rt, 1, 1, 0, 1, d, 0, 0, 0, 0);
    endtask
    task automatic i_lw(input int d);
        drv(1, 0, 0, 0, 0, 0, 1, d, 1, 0, 0, 0);
    endtask
    task automatic i_beq(input int rs, input int rt);
        drv(1, rs, rt, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    endtask

    // Drain the scoreboard with idle cycles and zero the stall counter.
    task automatic drain();
        repeat (DEPTH) begin
            drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            check_all("idle");
            tick();
        end
    endtask

    initial begin
        model_reset();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        drv(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check_all("rst");
        chk("rst_we_c",  int'(bus.pc_ifid_we), 1);
        chk("rst_bub_c", int'(bus.bubble), 0);
        chk("rst_sel_c", int'(bus.fwd_rs_sel), 0);
        tick();

        // Load followed by an EX consumer.
        drain();
        i_lw(8);              check_all("lwadd0"); tick();
        i_alu(9, 8, 8);       check_all("lwadd1");
        chk("lwadd_stall_we", int'(bus.pc_ifid_we), 0);
        chk("lwadd_stall_bub", int'(bus.bubble), 1);
        tick();
        i_alu(9, 8, 8);       check_all("lwadd2");
        chk("lwadd_go_we", int'(bus.pc_ifid_we), 1);
        chk("lwadd_cnt", int'(bus.stall_cnt), 1);
        tick();

        // ALU result feeding an ID-stage branch.
        drain();
        i_alu(8, 1, 2);       check_all("alubr0"); tick();
        i_beq(8, 0);          check_all("alubr1");
        chk("alubr_stall", int'(bus.pc_ifid_we), 0);
        tick();
        i_beq(8, 0);          check_all("alubr2");
        chk("alubr_sel", int'(bus.fwd_rs_sel), 2);
        tick();

        // Load feeding an ID-stage branch.
        drain();
        i_lw(8);              check_all("lwbr0"); tick();
        repeat (2) begin
            i_beq(8, 0);      check_all("lwbr_s");
            chk("lwbr_stall", int'(bus.pc_ifid_we), 0);
            tick();
        end
        i_beq(8, 0);          check_all("lwbr3");
        chk("lwbr_sel", int'(bus.fwd_rs_sel), 3);
        chk("lwbr_cnt", int'(bus.stall_cnt), 2);
        tick();

        // Younger load shadows an older ALU write of the same register.
        drain();
        i_alu(5, 1, 2);       check_all("shd0"); tick();
        i_lw(5);              check_all("shd1"); tick();
        i_alu(6, 5, 5);       check_all("shd2");
        chk("shd_stall", int'(bus.pc_ifid_we), 0);
        tick();
        i_alu(6, 5, 5);       check_all("shd3");
        chk("shd_cnt", int'(bus.stall_cnt), 1);
        tick();

        // Flush while a load-use hazard is pending.
        drain();
        i_lw(8);              check_all("fl0"); tick();
        drv(1, 8, 8, 1, 1, 0, 1, 9, 0, 1, 0, 0);
        check_all("fl1");
        chk("fl_we", int'(bus.pc_ifid_we), 1);
        chk("fl_bub", int'(bus.bubble), 1);
        tick();
        i_alu(10, 9, 9);      check_all("fl2");
        chk("fl_noins", int'(bus.fwd_rs_sel), 0);
        chk("fl_cnt", int'(bus.stall_cnt), 0);
        tick();

        // Pipe hold during a load-use hazard.
        drain();
        i_lw(8);              check_all("hd0"); tick();
        repeat (3) begin
            drv(1, 8, 8, 1, 1, 0, 1, 9, 0, 0, 1, 0);
            check_all("hd_h");
            chk("hd_bub", int'(bus.bubble), 0);
            tick();
        end
        i_alu(9, 8, 8);       check_all("hd1");
        chk("hd_stall", int'(bus.pc_ifid_we), 0);
        tick();
        i_alu(9, 8, 8);       check_all("hd2");
        chk("hd_cnt", int'(bus.stall_cnt), 1);
        tick();

        // Asynchronous reset in the middle of a stall.
        drain();
        i_lw(8);              check_all("rm0"); tick();
        i_alu(9, 8, 8);       check_all("rm1");
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rm2");
        chk("rm_we", int'(bus.pc_ifid_we), 1);
        #1 rst_n = 1'b1;
        tick();
        i_alu(9, 8, 8);       check_all("rm3");
        chk("rm_after", int'(bus.pc_ifid_we), 1);
        tick();

        // Random traffic over a small register set.
        for (int n = 0; n < 500; n++) begin
            drv(1'($urandom_range(0, 9) != 0),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 19) == 0));
            check_all("rnd");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
